// File: rtl/lift_scan_ctrl.sv
// -----------------------------------------------------------------------------
// lift_scan_ctrl
//
// Parametrised N-floor elevator controller. Car-panel and hall-call strobes are
// latched into a pending-floor bitmap, and the car serves them in SCAN order.
// While the car is moving it keeps its direction as long as there are requests
// ahead of it. When no requests remain ahead, it reverses toward the remaining
// requests. When nothing is pending, it parks in IDLE.
//
// Floor-to-floor travel takes TRAVEL_CYC cycles. The door stays open for
// DOOR_CYC cycles per stop. A repeat request for the current floor while the
// door is open restarts the door dwell.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   car_vld      in   car-panel button strobe (one cycle)
//   car_floor    in   floor requested from inside the car
//   hall_vld     in   hall-call button strobe (one cycle)
//   hall_floor   in   floor on which the hall call was made
//   elev_f_o     out  current floor of the car
//   dir_o        out  00 idle, 01 up, 10 down
//   door_open_o  out  door open
//   busy_o       out  controller is not idle
//   pending_o    out  registered pending-request bitmap
//   req_err_o    out  one-cycle pulse: out-of-range floor requested
// -----------------------------------------------------------------------------
module lift_scan_ctrl #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  car_vld,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  hall_vld,
  input  logic [FLOOR_W-1:0]    hall_floor,
  output logic [FLOOR_W-1:0]    elev_f_o,
  output logic [1:0]            dir_o,
  output logic                  door_open_o,
  output logic                  busy_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  req_err_o
);

  localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Counters load N-1 and the event fires on the edge where they read zero,
  // which gives exactly N cycles in the phase.
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYC - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_e;

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      elev_f_q, elev_f_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    req_err_q, req_err_d;

  logic [NUM_FLOORS-1:0]   req_set;
  logic [NUM_FLOORS-1:0]   stop_clr;
  logic [NUM_FLOORS-1:0]   above_mask, below_mask;
  logic                    door_reload;
  logic                    any_up, any_dn;
  dir_e                    scan_dir;
  logic [FLOOR_W-1:0]      next_floor;

  // ---------------------------------------------------------------------------
  // Request capture. A press for the current floor while the door is open
  // restarts the dwell instead of queueing a stop.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before any branch, so a path
  // that skips an assignment cannot infer a latch.
  always_comb begin
    req_set     = '0;
    req_err_d   = 1'b0;
    door_reload = 1'b0;
    if (car_vld) begin
      if ({1'b0, car_floor} >= FLOOR_LIMIT) begin
        req_err_d = 1'b1;
      end else if (state_q == ST_DOOR && car_floor == elev_f_q) begin
        door_reload = 1'b1;
      end else begin
        req_set[car_floor] = 1'b1;
      end
    end
    if (hall_vld) begin
      if ({1'b0, hall_floor} >= FLOOR_LIMIT) begin
        req_err_d = 1'b1;
      end else if (state_q == ST_DOOR && hall_floor == elev_f_q) begin
        door_reload = 1'b1;
      end else begin
        req_set[hall_floor] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Masks of floors strictly above and below the car.
  // ---------------------------------------------------------------------------
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(elev_f_q));
      below_mask[i] = (i < int'(elev_f_q));
    end
  end

  assign any_up = |(pending_q & above_mask);
  assign any_dn = |(pending_q & below_mask);

  // The direction for the next leg keeps the current heading if work remains
  // that way. Otherwise it turns toward whatever is left. With no heading,
  // up is preferred.
  always_comb begin
    scan_dir = DIR_NONE;
    if (dir_q == DIR_DN) begin
      if (any_dn)      scan_dir = DIR_DN;
      else if (any_up) scan_dir = DIR_UP;
    end else begin
      if (any_up)      scan_dir = DIR_UP;
      else if (any_dn) scan_dir = DIR_DN;
    end
  end

  assign next_floor = (dir_q == DIR_UP) ? (elev_f_q + FLOOR_W'(1))
                                        : (elev_f_q - FLOOR_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    elev_f_d = elev_f_q;
    cnt_d    = cnt_q;
    stop_clr = '0;

    case (state_q)
      ST_IDLE: begin
        dir_d = DIR_NONE;
        if (pending_q[elev_f_q]) begin
          state_d            = ST_DOOR;
          cnt_d              = DOOR_LOAD;
          stop_clr[elev_f_q] = 1'b1;
        end else if (scan_dir != DIR_NONE) begin
          state_d = ST_MOVE;
          dir_d   = scan_dir;
          cnt_d   = TRAVEL_LOAD;
        end
      end

      ST_MOVE: begin
        if (cnt_q == '0) begin
          elev_f_d = next_floor;
          if (pending_q[next_floor]) begin
            state_d              = ST_DOOR;
            cnt_d                = DOOR_LOAD;
            stop_clr[next_floor] = 1'b1;
          end else begin
            cnt_d = TRAVEL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DOOR: begin
        if (door_reload) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q == '0) begin
          dir_d = scan_dir;
          if (scan_dir == DIR_NONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MOVE;
            cnt_d   = TRAVEL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // A stop being opened this cycle absorbs any same-cycle press for that
  // floor, so the clear is applied after the new requests are merged in.
  assign pending_d = (pending_q | req_set) & ~stop_clr;

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NONE;
      elev_f_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      elev_f_q  <= elev_f_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      req_err_q <= req_err_d;
    end
  end

  assign elev_f_o    = elev_f_q;
  assign dir_o       = dir_q;
  assign door_open_o = (state_q == ST_DOOR);
  assign busy_o      = (state_q != ST_IDLE);
  assign pending_o   = pending_q;
  assign req_err_o   = req_err_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lift_scan_ctrl
//
// Self-checking bench for lift_scan_ctrl, instantiated with six floors so that
// out-of-range floor codes (6, 7) are reachable on a 3-bit floor bus.
//
// A behavioural model of the lift runs in lock-step with the DUT. The model
// tracks the mode, the remaining phase time, and the set of requested floors.
// After every clock edge, each DUT output is compared against this model.
//
// The bench also contains a table of single-strobe capture vectors and
// hand-written sequences for the timing, SCAN-order, door-extension and
// reset corner cases. Random traffic is added on top.
// -----------------------------------------------------------------------------
module tb_lift_scan_ctrl;

  localparam int NF = 6;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 6;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk;
  logic          rst_n;
  logic          car_vld;
  logic [FW-1:0] car_floor;
  logic          hall_vld;
  logic [FW-1:0] hall_floor;
  logic [FW-1:0] elev_f_o;
  logic [1:0]    dir_o;
  logic          door_open_o;
  logic          busy_o;
  logic [NF-1:0] pending_o;
  logic          req_err_o;

  int errors = 0;
  int checks = 0;

  lift_scan_ctrl #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .TRAVEL_CYC (TC),
    .DOOR_CYC   (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .car_vld     (car_vld),
    .car_floor   (car_floor),
    .hall_vld    (hall_vld),
    .hall_floor  (hall_floor),
    .elev_f_o    (elev_f_o),
    .dir_o       (dir_o),
    .door_open_o (door_open_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o),
    .req_err_o   (req_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. Time is counted as cycles remaining in the current phase.
  // Direction is represented as -1, 0 or +1.
  // ---------------------------------------------------------------------------
  int m_floor;
  int m_dir;
  int m_mode;
  int m_timer;
  bit m_pend[NF];
  bit m_err;

  int stops[$];
  int stop_dirs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_floor = 0;
    m_dir   = 0;
    m_mode  = M_IDLE;
    m_timer = 0;
    m_err   = 1'b0;
    for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
  endtask

  function automatic bit model_any(input bit above);
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f] && (above ? (f > m_floor) : (f < m_floor))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Keep heading if work remains that way, else turn; no heading prefers up.
  function automatic int model_pick();
    bit up;
    bit dn;
    up = model_any(1'b1);
    dn = model_any(1'b0);
    if (m_dir == -1) return dn ? -1 : (up ? 1 : 0);
    return up ? 1 : (dn ? -1 : 0);
  endfunction

  task automatic model_req(input bit v, input int f, inout bit reload, inout bit set_f[NF]);
    if (v) begin
      if (f >= NF) m_err = 1'b1;
      else if (m_mode == M_DOOR && f == m_floor) reload = 1'b1;
      else set_f[f] = 1'b1;
    end
  endtask

  task automatic model_step(input bit cv, input int cf, input bit hv, input int hf);
    bit reload;
    bit set_f[NF];
    int stop;
    int d;
    reload = 1'b0;
    stop   = -1;
    m_err  = 1'b0;
    for (int f = 0; f < NF; f++) set_f[f] = 1'b0;
    model_req(cv, cf, reload, set_f);
    model_req(hv, hf, reload, set_f);

    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin
          m_mode  = M_DOOR;
          m_timer = DC;
          stop    = m_floor;
        end else begin
          d = model_pick();
          if (d != 0) begin
            m_mode  = M_MOVE;
            m_dir   = d;
            m_timer = TC;
          end
        end
      end
      M_MOVE: begin
        m_timer--;
        if (m_timer == 0) begin
          m_floor += m_dir;
          if (m_pend[m_floor]) begin
            m_mode  = M_DOOR;
            m_timer = DC;
            stop    = m_floor;
          end else begin
            m_timer = TC;
          end
        end
      end
      default: begin
        if (reload) begin
          m_timer = DC;
        end else begin
          m_timer--;
          if (m_timer == 0) begin
            d = model_pick();
            if (d == 0) begin
              m_mode = M_IDLE;
              m_dir  = 0;
            end else begin
              m_mode  = M_MOVE;
              m_dir   = d;
              m_timer = TC;
            end
          end
        end
      end
    endcase

    for (int f = 0; f < NF; f++) if (set_f[f]) m_pend[f] = 1'b1;
    if (stop >= 0) m_pend[stop] = 1'b0;
  endtask

  task automatic compare_all();
    logic [NF-1:0] ep;
    for (int f = 0; f < NF; f++) ep[f] = m_pend[f];
    check("model_floor",   32'(elev_f_o),    32'(m_floor));
    check("model_dir",     32'(dir_o),       (m_dir == 1) ? 32'd1 : ((m_dir == -1) ? 32'd2 : 32'd0));
    check("model_door",    32'(door_open_o), 32'(m_mode == M_DOOR));
    check("model_busy",    32'(busy_o),      32'(m_mode != M_IDLE));
    check("model_pending", 32'(pending_o),   32'(ep));
    check("model_err",     32'(req_err_o),   32'(m_err));
  endtask

  // One clock edge: capture inputs, advance the model, compare just after.
  task automatic step();
    bit cv;
    bit hv;
    bit rn;
    int cf;
    int hf;
    cv = car_vld;
    hv = hall_vld;
    rn = rst_n;
    cf = int'(car_floor);
    hf = int'(hall_floor);
    @(posedge clk);
    if (!rn) model_reset();
    else     model_step(cv, cf, hv, hf);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit cv, input int cf, input bit hv, input int hf);
    car_vld    = cv;
    car_floor  = FW'(cf);
    hall_vld   = hv;
    hall_floor = FW'(hf);
  endtask

  task automatic release_inputs();
    car_vld  = 1'b0;
    hall_vld = 1'b0;
  endtask

  // Asserts reset off the clock edge, checks the asynchronous clear, holds it
  // through one edge, and then releases.
  task automatic do_reset();
    release_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    rst_n = 1'b1;
  endtask

  // Steps until the controller returns to idle, logging every door opening.
  task automatic run_until_idle(input int budget);
    bit prev_door;
    bit done;
    int n;
    stops.delete();
    stop_dirs.delete();
    prev_door = door_open_o;
    done      = 1'b0;
    n         = 0;
    while (!done && n < budget) begin
      step();
      n++;
      if (door_open_o && !prev_door) begin
        stops.push_back(int'(elev_f_o));
        stop_dirs.push_back(int'(dir_o));
      end
      prev_door = door_open_o;
      if (!busy_o) done = 1'b1;
    end
    check("idle_within_budget", 32'(done), 32'd1);
  endtask

  typedef struct {
    bit            cv;
    logic [FW-1:0] cf;
    bit            hv;
    logic [FW-1:0] hf;
    logic [NF-1:0] exp_pend;
    bit            exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 6'b001000, 1'b0};
    vecs[1] = '{1'b1, 3'd2, 1'b1, 3'd4, 6'b010100, 1'b0};
    vecs[2] = '{1'b1, 3'd5, 1'b1, 3'd5, 6'b100000, 1'b0};
    vecs[3] = '{1'b1, 3'd7, 1'b0, 3'd1, 6'b000000, 1'b1};
    vecs[4] = '{1'b0, 3'd2, 1'b1, 3'd6, 6'b000000, 1'b1};
    vecs[5] = '{1'b1, 3'd6, 1'b1, 3'd1, 6'b000010, 1'b1};
    vecs[6] = '{1'b0, 3'd4, 1'b0, 3'd7, 6'b000000, 1'b0};
    vecs[7] = '{1'b0, 3'd0, 1'b1, 3'd0, 6'b000001, 1'b0};

    rst_n = 1'b1;
    release_inputs();
    car_floor  = '0;
    hall_floor = '0;
    model_reset();
    #2;

    // Reset, then a quiet idle period.
    do_reset();
    repeat (10) step();
    check("idle_floor",   32'(elev_f_o),    32'd0);
    check("idle_dir",     32'(dir_o),       32'd0);
    check("idle_door",    32'(door_open_o), 32'd0);
    check("idle_busy",    32'(busy_o),      32'd0);
    check("idle_pending", 32'(pending_o),   32'd0);
    check("idle_err",     32'(req_err_o),   32'd0);

    // Single trip 0 -> 3 with exact edge timing.
    do_reset();
    drive(1'b1, 3, 1'b0, 0);
    step();                                         // E0
    release_inputs();
    check("e0_pending", 32'(pending_o), 32'b001000);
    check("e0_busy",    32'(busy_o),    32'd0);
    step();                                         // E1
    check("e1_busy",    32'(busy_o),    32'd1);
    check("e1_dir",     32'(dir_o),     32'd1);
    check("e1_door",    32'(door_open_o), 32'd0);
    repeat (4) step();                              // E5
    check("e5_floor",   32'(elev_f_o),  32'd1);
    repeat (4) step();                              // E9
    check("e9_floor",   32'(elev_f_o),  32'd2);
    repeat (4) step();                              // E13
    check("e13_floor",  32'(elev_f_o),  32'd3);
    check("e13_door",   32'(door_open_o), 32'd1);
    check("e13_pending", 32'(pending_o), 32'd0);
    repeat (5) step();                              // E18
    check("e18_door",   32'(door_open_o), 32'd1);
    step();                                         // E19
    check("e19_door",   32'(door_open_o), 32'd0);
    check("e19_busy",   32'(busy_o),    32'd0);
    check("e19_dir",    32'(dir_o),     32'd0);

    // SCAN order: 5 requested; 2 arrives ahead, 1 arrives just behind.
    do_reset();
    drive(1'b1, 5, 1'b0, 0);
    step();                                         // E0
    release_inputs();
    step();                                         // E1
    drive(1'b0, 0, 1'b1, 2);
    step();                                         // E2
    release_inputs();
    repeat (3) step();                              // E5, car at floor 1
    drive(1'b0, 0, 1'b1, 1);
    step();                                         // E6
    release_inputs();
    run_until_idle(300);
    check("scan_nstops", 32'(stops.size()), 32'd3);
    if (stops.size() >= 3) begin
      check("scan_stop0", 32'(stops[0]), 32'd2);
      check("scan_stop1", 32'(stops[1]), 32'd5);
      check("scan_stop2", 32'(stops[2]), 32'd1);
      check("scan_dir_at_1", 32'(stop_dirs[2]), 32'd2);
    end

    // Out-of-range floor, then same-floor door handling at floor 0.
    do_reset();
    drive(1'b1, 7, 1'b0, 0);
    step();
    release_inputs();
    check("oor_err",     32'(req_err_o), 32'd1);
    check("oor_pending", 32'(pending_o), 32'd0);
    step();
    check("oor_err_drop", 32'(req_err_o), 32'd0);

    do_reset();
    drive(1'b1, 0, 1'b1, 0);
    step();                                         // E0
    release_inputs();
    check("f0_pending", 32'(pending_o), 32'b000001);
    step();                                         // E1
    check("f0_door",    32'(door_open_o), 32'd1);
    check("f0_floor",   32'(elev_f_o),  32'd0);
    check("f0_dir",     32'(dir_o),     32'd0);
    repeat (2) step();                              // E3
    drive(1'b1, 0, 1'b0, 0);
    step();                                         // E4, dwell restarts
    release_inputs();
    check("reload_pending", 32'(pending_o), 32'd0);
    repeat (3) step();                              // E7
    check("reload_e7_door", 32'(door_open_o), 32'd1);
    repeat (2) step();                              // E9
    check("reload_e9_door", 32'(door_open_o), 32'd1);
    step();                                         // E10
    check("reload_e10_door", 32'(door_open_o), 32'd0);
    check("reload_e10_busy", 32'(busy_o), 32'd0);

    // Simultaneous car 2 and hall 4.
    do_reset();
    drive(1'b1, 2, 1'b1, 4);
    step();
    release_inputs();
    check("simul_pending", 32'(pending_o), 32'b010100);
    run_until_idle(300);
    check("simul_nstops", 32'(stops.size()), 32'd2);
    if (stops.size() >= 2) begin
      check("simul_stop0", 32'(stops[0]), 32'd2);
      check("simul_stop1", 32'(stops[1]), 32'd4);
    end

    // Reset mid-move between floors 2 and 3.
    do_reset();
    drive(1'b1, 4, 1'b0, 0);
    step();                                         // E0
    release_inputs();
    repeat (10) step();                             // E10
    check("mid_floor", 32'(elev_f_o), 32'd2);
    check("mid_busy",  32'(busy_o),   32'd1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("arst_floor",   32'(elev_f_o),    32'd0);
    check("arst_pending", 32'(pending_o),   32'd0);
    check("arst_door",    32'(door_open_o), 32'd0);
    check("arst_busy",    32'(busy_o),      32'd0);
    check("arst_dir",     32'(dir_o),       32'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 1, 1'b0, 0);
    step();
    release_inputs();
    run_until_idle(200);
    check("post_rst_nstops", 32'(stops.size()), 32'd1);
    if (stops.size() >= 1) check("post_rst_stop", 32'(stops[0]), 32'd1);

    // Table-driven capture vectors, each from a fresh reset at floor 0.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].cv, int'(vecs[i].cf), vecs[i].hv, int'(vecs[i].hf));
      step();
      release_inputs();
      check($sformatf("vec%0d_pending", i), 32'(pending_o), 32'(vecs[i].exp_pend));
      check($sformatf("vec%0d_err", i),     32'(req_err_o), 32'(vecs[i].exp_err));
      step();
      check($sformatf("vec%0d_err_drop", i), 32'(req_err_o), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      car_vld    = ($urandom_range(0, 7) == 0);
      car_floor  = FW'($urandom_range(0, 7));
      hall_vld   = ($urandom_range(0, 9) == 0);
      hall_floor = FW'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    release_inputs();
    run_until_idle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lift_scan_ctrl.md
Name: lift_scan_ctrl

Overview:
- Parametrised elevator controller for an N-floor shaft.
- Latches car-panel and hall-call requests into a pending-floor register and serves them in SCAN (elevator-algorithm) order.
- Times floor-to-floor travel and door dwell with internal counters, and reports position, direction, door state and busy.
- Sits between the button/decoder front end and the car/door indicators; successor to the fixed 8-floor, single-request lift controller.

Parameters:
- NUM_FLOORS, 8, number of floors served (2..16); floors numbered 0..NUM_FLOORS-1.
- FLOOR_W, 3, floor-index width; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- TRAVEL_CYC, 4, clock cycles per one-floor move (>=1).
- DOOR_CYC, 6, clock cycles the door stays open per stop (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- car_vld  in  1  car-panel button press strobe, one cycle.
- car_floor  in  FLOOR_W  floor requested from inside the car.
- hall_vld  in  1  hall-call button press strobe, one cycle.
- hall_floor  in  FLOOR_W  floor on which the hall call was made.
- elev_f_o  out  FLOOR_W  current floor of the car.
- dir_o  out  2  00 idle, 01 up, 10 down.
- door_open_o  out  1  door open.
- busy_o  out  1  high whenever state != IDLE.
- pending_o  out  NUM_FLOORS  registered pending-request bitmap.
- req_err_o  out  1  one-cycle pulse: out-of-range floor requested.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: elev_f_o=0, dir_o=00, door_open_o=0, busy_o=0, pending_o=0, req_err_o=0.
  - Internal: state=IDLE, counters=0.
  - Applies mid-operation with no completion of the move or door cycle in progress.
- Request capture (every cycle, all states):
  - Each valid strobe with floor < NUM_FLOORS sets pending[floor] at the next edge.
  - car and hall in the same cycle both set their bits; the same floor in both merges into one bit.
  - floor >= NUM_FLOORS: bitmap unchanged; req_err_o=1 for exactly the next cycle. Either source can raise it.
  - A request for elev_f_o while in DOOR does not set the bit; instead it reloads the door counter to DOOR_CYC.
- State machine (IDLE, MOVE, DOOR):
  - IDLE, pending==0: stay; dir_o=00.
  - IDLE, pending[elev_f_o]=1: go to DOOR next edge and clear that bit.
  - IDLE, other pending bit set: dir=up if any bit above elev_f_o, else down; go to MOVE with the travel counter loaded.
  - MOVE:
    - The counter runs TRAVEL_CYC cycles; on the final edge elev_f_o steps ±1 per dir.
    - If the new floor is pending, that same edge enters DOOR and clears its bit; otherwise MOVE continues.
    - Bits set during MOVE ahead of the car in the current direction are served on this pass.
  - DOOR:
    - door_open_o=1 for DOOR_CYC cycles (longer if reloaded).
    - On expiry, if any pending bit lies in dir, go to MOVE with the same dir.
    - Else if any pending bit lies opposite, go to MOVE with dir reversed.
    - Else go to IDLE with dir_o=00.
- Boundaries:
  - The car never steps below floor 0 or above NUM_FLOORS-1; direction is always chosen toward an existing pending bit.
  - door_open_o is never 1 while in MOVE.
- Arithmetic:
  - Floor compares are unsigned.
  - "Above" and "below" masks are derived from elev_f_o over NUM_FLOORS bits.
  - Counters are sized from max(TRAVEL_CYC, DOOR_CYC).

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy_o=0, dir_o=00.
- Defaults; at floor 0, car_vld, car_floor=3 sampled at edge E0:
  - pending_o=0000_1000 after E0; MOVE and dir_o=01 at E1.
  - elev_f_o=1/2/3 at E5/E9/E13; DOOR at E13 with bit 3 cleared.
  - door_open_o high E13..E18; IDLE and busy_o=0 at E19.
- SCAN ordering:
  - Request floor 5; while moving 0->1, hall_floor=2 and hall_floor=1 arrive.
  - Stops at 2, then 5; reverses (dir_o=10) and stops at 1; then IDLE.
- NUM_FLOORS=6, car_floor=7 -> req_err_o one cycle, pending_o unchanged. Also: hall_floor=0 and car_floor=0 in the same cycle at floor 0 -> DOOR with no move; request for 0 during DOOR extends door to DOOR_CYC from that request.
- Simultaneous car_floor=2 and hall_floor=4 -> pending_o=0001_0100 after one edge; both served upward in order 2, 4.
- rst_n low for 1 cycle mid-MOVE between floors 2 and 3 -> outputs reset asynchronously: elev_f_o=0, pending_o=0, door_open_o=0; controller accepts new requests normally after release.
